leaf_run_ctrl: RTL and testbench

Run sequencer for one operator page inside a leaf wrapper. It drives the HLS operator's `ap_start` through a programmed number of invocations using the `ap_ctrl_hs` protocol, and counts output tokens by monitoring the operator→leaf_interface handshake. A no-progress watchdog pulses `resend` toward the BFT. After repeated stalls it parks in an error state. It sits between the page's command source and the operator/leaf_interface pair, replacing the free-running `ap_start` tie-off.

---
 rtl/leaf_run_ctrl.sv | 178 +++++++++++++++++
 tb/tb_leaf_run_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : leaf_run_ctrl
// Desc     : ap_ctrl_hs run sequencer for one operator page, with output-token
//            counting and a no-progress watchdog that requests BFT resends.
// Revision : 1.0 - initial release
// ============================================================================
module leaf_run_ctrl #(
    parameter int RUN_BITS   = 16,
    parameter int TO_BITS    = 16,
    parameter int MAX_RESEND = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_start,
    input  logic [RUN_BITS-1:0] cmd_runs,
    input  logic [TO_BITS-1:0]  cmd_timeout,
    input  logic                cmd_abort,
    output logic                ap_start,
    input  logic                ap_ready,
    input  logic                ap_done,
    input  logic                out_vld,
    input  logic                out_ack,
    output logic                resend,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [RUN_BITS-1:0] runs_done,
    output logic [31:0]         tokens
);

    localparam int                   c_RS_BITS  = $clog2(MAX_RESEND + 1);
    localparam logic [c_RS_BITS-1:0] c_RS_LIMIT = c_RS_BITS'(MAX_RESEND);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_RUN   = 3'd2;
    localparam logic [2:0] c_ST_DONE  = 3'd3;
    localparam logic [2:0] c_ST_ERROR = 3'd4;

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [RUN_BITS-1:0]  r_runs;
    logic [TO_BITS-1:0]   r_timeout;
    logic [TO_BITS-1:0]   r_wd_cnt;
    logic [c_RS_BITS-1:0] r_rs_cnt;
    logic [RUN_BITS-1:0]  r_runs_done;
    logic [31:0]          r_tokens;
    logic                 r_ap_start;
    logic                 r_resend;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    logic                 w_active;
    logic                 w_abort;
    logic                 w_start_acc;
    logic                 w_token;
    logic                 w_progress;
    logic                 w_wd_en;
    logic                 w_wd_fire;
    logic                 w_to_error;
    logic                 w_run_end;
    logic                 w_more_runs;
    logic [RUN_BITS:0]    w_runs_inc;

    assign w_active    = (r_state == c_ST_START) || (r_state == c_ST_RUN);
    assign w_abort     = cmd_abort && (r_state != c_ST_IDLE);
    assign w_start_acc = cmd_start && !cmd_abort && (r_state == c_ST_IDLE);
    assign w_token     = out_vld && out_ack;
    assign w_progress  = w_token || ap_ready || ap_done;
    assign w_wd_en     = w_active && (r_timeout != '0);
    assign w_wd_fire   = w_wd_en && !w_progress && (r_wd_cnt == r_timeout);
    // The fire that would exceed the resend budget escalates instead of pulsing.
    assign w_to_error  = w_wd_fire && (r_rs_cnt == c_RS_LIMIT);
    assign w_run_end   = ((r_state == c_ST_START) && ap_ready && ap_done) ||
                         ((r_state == c_ST_RUN) && ap_done);
    assign w_runs_inc  = {1'b0, r_runs_done} + (RUN_BITS + 1)'(1);
    assign w_more_runs = w_runs_inc < {1'b0, r_runs};

    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start_acc) begin
                        w_state_nxt = (cmd_runs == '0) ? c_ST_DONE : c_ST_START;
                    end
                end
                c_ST_START: begin
                    if (w_to_error) begin
                        w_state_nxt = c_ST_ERROR;
                    end else if (ap_ready) begin
                        if (!ap_done) begin
                            w_state_nxt = c_ST_RUN;
                        end else begin
                            w_state_nxt = w_more_runs ? c_ST_START : c_ST_DONE;
                        end
                    end
                end
                c_ST_RUN: begin
                    if (w_to_error) begin
                        w_state_nxt = c_ST_ERROR;
                    end else if (ap_done) begin
                        w_state_nxt = w_more_runs ? c_ST_START : c_ST_DONE;
                    end
                end
                c_ST_DONE:  w_state_nxt = c_ST_IDLE;
                c_ST_ERROR: w_state_nxt = c_ST_ERROR;
                default:    w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= c_ST_IDLE;
            r_runs      <= '0;
            r_timeout   <= '0;
            r_wd_cnt    <= '0;
            r_rs_cnt    <= '0;
            r_runs_done <= '0;
            r_tokens    <= '0;
            r_ap_start  <= 1'b0;
            r_resend    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ap_start <= (w_state_nxt == c_ST_START);
            // busy stays up across the done pulse and drops the cycle after.
            r_busy     <= (w_state_nxt != c_ST_IDLE);
            r_done     <= (w_state_nxt == c_ST_DONE);
            r_err      <= (w_state_nxt == c_ST_ERROR);
            r_resend   <= w_wd_fire && !w_to_error && !w_abort;

            if (w_start_acc) begin
                r_runs      <= cmd_runs;
                r_timeout   <= cmd_timeout;
                r_runs_done <= '0;
                r_tokens    <= '0;
                r_wd_cnt    <= '0;
                r_rs_cnt    <= '0;
            end else if (w_active && !w_abort) begin
                if (w_token) begin
                    r_tokens <= r_tokens + 32'd1;
                end
                if (w_run_end) begin
                    r_runs_done <= w_runs_inc[RUN_BITS-1:0];
                end
                if (w_progress) begin
                    r_wd_cnt <= '0;
                    r_rs_cnt <= '0;
                end else if (w_wd_fire) begin
                    r_wd_cnt <= '0;
                    if (!w_to_error) begin
                        r_rs_cnt <= r_rs_cnt + c_RS_BITS'(1);
                    end
                end else if (w_wd_en) begin
                    r_wd_cnt <= r_wd_cnt + TO_BITS'(1);
                end
            end
        end
    end

    assign ap_start  = r_ap_start;
    assign resend    = r_resend;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign runs_done = r_runs_done;
    assign tokens    = r_tokens;

endmodule
`default_nettype wire

// File: tb/tb_leaf_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_leaf_run_ctrl
// Desc     : directed + randomized bench for leaf_run_ctrl against a
//            cycle-count reference model of the run and watchdog rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_leaf_run_ctrl;

    localparam int c_MAXRS = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_start;
    logic [15:0] cmd_runs;
    logic [15:0] cmd_timeout;
    logic        cmd_abort;
    logic        ap_start;
    logic        ap_ready;
    logic        ap_done;
    logic        out_vld;
    logic        out_ack;
    logic        resend;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] runs_done;
    logic [31:0] tokens;

    leaf_run_ctrl #(
        .RUN_BITS   (16),
        .TO_BITS    (16),
        .MAX_RESEND (c_MAXRS)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_start   (cmd_start),
        .cmd_runs    (cmd_runs),
        .cmd_timeout (cmd_timeout),
        .cmd_abort   (cmd_abort),
        .ap_start    (ap_start),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .out_vld     (out_vld),
        .out_ack     (out_ack),
        .resend      (resend),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .runs_done   (runs_done),
        .tokens      (tokens)
    );

    always #5 clk = ~clk;

    // Reference model: job flags plus a count of consecutive quiet edges.
    bit          m_job, m_launch, m_finish, m_fault, e_resend;
    int          m_runs_left, m_tmo, m_quiet;
    logic [15:0] m_runs_done;
    logic [31:0] m_tokens;

    int n_checks = 0;
    int n_fail   = 0;

    int n_rise, n_hi, n_done, n_rs, err_t, done_t;
    int rs_t[2];
    bit prev_ap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_step();
        bit tok, prog, counted;
        tok      = out_vld && out_ack;
        prog     = tok || ap_ready || ap_done;
        e_resend = 1'b0;
        if (!reset) begin
            m_job = 0; m_launch = 0; m_finish = 0; m_fault = 0;
            m_runs_done = '0; m_tokens = '0; m_quiet = 0;
        end else if (m_finish) begin
            m_finish = 0;
            m_job    = 0;
        end else if (!m_job) begin
            if (cmd_start && !cmd_abort) begin
                m_runs_left = int'(cmd_runs);
                m_tmo       = int'(cmd_timeout);
                m_runs_done = '0;
                m_tokens    = '0;
                m_quiet     = 0;
                m_job       = 1;
                if (cmd_runs == 16'd0) m_finish = 1;
                else                   m_launch = 1;
            end
        end else if (cmd_abort) begin
            m_job = 0; m_launch = 0; m_fault = 0;
        end else if (!m_fault) begin
            if (tok) m_tokens = m_tokens + 32'd1;
            counted = ap_done && (!m_launch || ap_ready);
            if (ap_ready) m_launch = 0;
            if (counted) begin
                m_runs_done = m_runs_done + 16'd1;
                m_runs_left--;
                if (m_runs_left == 0) m_finish = 1;
                else                  m_launch = 1;
            end
            if (prog) begin
                m_quiet = 0;
            end else if (m_tmo != 0) begin
                m_quiet++;
                if (m_quiet % (m_tmo + 1) == 0) begin
                    if (m_quiet / (m_tmo + 1) <= c_MAXRS) e_resend = 1;
                    else begin m_fault = 1; m_launch = 0; end
                end
            end
        end
    endtask

    task automatic compare_all();
        check("ap_start", 32'(ap_start), 32'(m_launch));
        if (!m_finish) check("busy", 32'(busy), 32'(m_job));
        check("done", 32'(done), 32'(m_finish));
        check("err", 32'(err), 32'(m_fault));
        check("resend", 32'(resend), 32'(e_resend));
        check("runs_done", 32'(runs_done), 32'(m_runs_done));
        check("tokens", tokens, m_tokens);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic record(input int t);
        if (ap_start) n_hi++;
        if (ap_start && !prev_ap) n_rise++;
        prev_ap = ap_start;
        if (done) begin n_done++; done_t = t; end
        if (resend) begin
            if (n_rs < 2) rs_t[n_rs] = t;
            n_rs++;
        end
        if (err && err_t < 0) err_t = t;
    endtask

    task automatic quiet_inputs();
        cmd_start = 0; cmd_abort = 0;
        ap_ready = 0; ap_done = 0; out_vld = 0; out_ack = 0;
    endtask

    // mode: 0 random, 1 scripted, 2 combinational, 3 never ready,
    //       4 stall then recover, 5 ready then endless tokens
    task automatic run_job(input int mode, input int runs, input int tmo, input int limit);
        int t = 0, pc = 0, stall = 0, fault_age = 0;
        bit prev_launch = 0, prev_run = 0, run_ph;
        n_rise = 0; n_hi = 0; n_done = 0; n_rs = 0; err_t = -1; done_t = -1;
        rs_t[0] = -1; rs_t[1] = -1; prev_ap = 0;
        quiet_inputs();
        cmd_start = 1; cmd_runs = 16'(runs); cmd_timeout = 16'(tmo);
        tick();
        record(0);
        while (m_job && t < limit) begin
            run_ph = m_job && !m_launch && !m_finish && !m_fault;
            if (m_launch != prev_launch || run_ph != prev_run) pc = 0;
            else pc++;
            prev_launch = m_launch;
            prev_run    = run_ph;
            quiet_inputs();
            case (mode)
                0: begin
                    if (stall > 0) stall--;
                    else begin
                        if ($urandom_range(0, 39) == 0) stall = $urandom_range(5, 30);
                        ap_ready = m_launch && ($urandom_range(0, 2) == 0);
                        ap_done  = (run_ph && $urandom_range(0, 3) == 0) ||
                                   (ap_ready && $urandom_range(0, 3) == 0) ||
                                   (m_launch && $urandom_range(0, 15) == 0);
                        out_vld  = ($urandom_range(0, 1) == 1);
                        out_ack  = ($urandom_range(0, 1) == 1);
                    end
                    if ($urandom_range(0, 9) == 0) begin
                        cmd_start = 1;
                        cmd_runs  = 16'($urandom_range(0, 7));
                    end
                    if (m_fault) begin
                        fault_age++;
                        if (fault_age > 3) cmd_abort = 1;
                    end else if ($urandom_range(0, 199) == 0) begin
                        cmd_abort = 1;
                    end
                end
                1, 4: begin
                    if (mode == 4 && t < 15) begin
                        // silent operator
                    end else if (mode == 4 && t == 15) begin
                        out_vld = 1; out_ack = 1;
                    end else begin
                        ap_ready = m_launch && pc >= 2;
                        ap_done  = run_ph && pc >= 5;
                        out_vld  = run_ph && pc >= 1 && pc <= 4;
                        out_ack  = out_vld;
                        if (run_ph && pc == 3) begin
                            cmd_start = 1; cmd_runs = 16'd9;
                        end
                    end
                end
                2: begin
                    ap_ready = m_launch;
                    ap_done  = m_launch;
                end
                5: begin
                    ap_ready = m_launch;
                    out_vld  = run_ph;
                    out_ack  = run_ph;
                end
                default: ;
            endcase
            tick();
            t++;
            record(t);
            if (mode == 5 && m_tokens == 32'd7) break;
        end
        quiet_inputs();
    endtask

    initial begin
        quiet_inputs();
        cmd_runs = '0; cmd_timeout = '0;
        reset = 0;
        tick();
        tick();
        reset = 1;
        tick();

        // zero-run job: done right after the command, operator never started
        run_job(3, 0, 0, 10);
        check("zero_done_t", 32'(done_t), 32'd0);
        check("zero_rise", 32'(n_rise), 32'd0);
        check("zero_ndone", 32'(n_done), 32'd1);

        // basic scripted operator, with an ignored cmd_start in RUN
        run_job(1, 3, 0, 200);
        check("basic_rise", 32'(n_rise), 32'd3);
        check("basic_ndone", 32'(n_done), 32'd1);
        check("basic_resend", 32'(n_rs), 32'd0);
        check("basic_runs", 32'(runs_done), 32'd3);
        check("basic_tokens", tokens, 32'd12);
        check("basic_busy_end", 32'(busy), 32'd0);

        // combinational operator
        run_job(2, 4, 0, 50);
        check("comb_hi", 32'(n_hi), 32'd4);
        check("comb_rise", 32'(n_rise), 32'd1);
        check("comb_done_t", 32'(done_t), 32'd4);
        check("comb_runs", 32'(runs_done), 32'd4);

        // watchdog escalation to ERROR, then abort
        run_job(3, 1, 10, 40);
        check("wd_rs0_t", 32'(rs_t[0]), 32'd11);
        check("wd_rs1_t", 32'(rs_t[1]), 32'd22);
        check("wd_nrs", 32'(n_rs), 32'd2);
        check("wd_err_t", 32'(err_t), 32'd33);
        check("wd_err_apstart", 32'(ap_start), 32'd0);
        cmd_abort = 1;
        tick();
        cmd_abort = 0;
        check("abort_err", 32'(err), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        tick();

        // stall then recovery
        run_job(4, 1, 10, 200);
        check("rec_nrs", 32'(n_rs), 32'd1);
        check("rec_ndone", 32'(n_done), 32'd1);
        check("rec_runs", 32'(runs_done), 32'd1);

        // randomized jobs
        for (int j = 0; j < 40; j++) begin
            int tmo;
            tmo = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(3, 9));
            run_job(0, int'($urandom_range(1, 5)), tmo, 400);
            tick();
            check("rand_job_end", 32'(busy), 32'd0);
        end

        // reset in the middle of RUN
        run_job(5, 5, 0, 50);
        check("pre_reset_tokens", tokens, 32'd7);
        reset = 0;
        tick();
        check("rst_ap_start", 32'(ap_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tokens", tokens, 32'd0);
        check("rst_runs", 32'(runs_done), 32'd0);
        reset = 1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
